// File: rtl/store_queue_if.sv
// Store queue interface: dispatch allocation, address-stage capture,
// retire/branch-resolve control and the D-cache drain request.
// The "master" modport is the pipeline side, "slave" is the queue itself.
// Load-forwarding signals exist only when SQ_FORWARD_EN is defined.
interface store_queue_if #(
   parameter int SQ_DEPTH = 8,
   parameter int B_MASK_W = 4,
   parameter int IDX_W    = $clog2(SQ_DEPTH)
);
   // dispatch allocation
   logic                alloc_valid;
   logic [B_MASK_W-1:0] alloc_bm;
   logic                alloc_ready;
   logic [IDX_W-1:0]    alloc_idx;
   // address-stage packet
   logic                sq_in_valid;
   logic [IDX_W-1:0]    sq_in_idx;
   logic [31:0]         sq_in_addr;
   logic [31:0]         sq_in_data;
   logic [3:0]          sq_in_byte_mask;
   // ROB retire and branch resolution
   logic                retire_valid;
   logic [B_MASK_W-1:0] b_mm_resolve;
   logic                b_mm_mispred;
   // D-cache drain
   logic                dc_req_valid;
   logic [31:0]         dc_req_addr;
   logic [31:0]         dc_req_data;
   logic [3:0]          dc_req_byte_mask;
   logic                dc_req_ready;
   // occupancy
   logic [IDX_W:0]      sq_count;
`ifdef SQ_FORWARD_EN
   // store-to-load forwarding
   logic                ld_valid;
   logic [31:0]         ld_addr;
   logic [3:0]          ld_byte_mask;
   logic [IDX_W:0]      ld_tail;
   logic                fwd_hit;
   logic [31:0]         fwd_data;
`endif

   modport master (
      output alloc_valid, alloc_bm,
      input  alloc_ready, alloc_idx,
      output sq_in_valid, sq_in_idx, sq_in_addr, sq_in_data, sq_in_byte_mask,
      output retire_valid, b_mm_resolve, b_mm_mispred,
      input  dc_req_valid, dc_req_addr, dc_req_data, dc_req_byte_mask,
      output dc_req_ready,
      input  sq_count
`ifdef SQ_FORWARD_EN
      ,
      output ld_valid, ld_addr, ld_byte_mask, ld_tail,
      input  fwd_hit, fwd_data
`endif
   );

   modport slave (
      input  alloc_valid, alloc_bm,
      output alloc_ready, alloc_idx,
      input  sq_in_valid, sq_in_idx, sq_in_addr, sq_in_data, sq_in_byte_mask,
      input  retire_valid, b_mm_resolve, b_mm_mispred,
      output dc_req_valid, dc_req_addr, dc_req_data, dc_req_byte_mask,
      input  dc_req_ready,
      output sq_count
`ifdef SQ_FORWARD_EN
      ,
      output fwd_hit, fwd_data,
      input  ld_valid, ld_addr, ld_byte_mask, ld_tail
`endif
   );
endinterface

// File: rtl/store_queue.sv
// Circular store queue sitting behind the store address stage.
// Entries are allocated in program order, filled by the address stage,
// committed by the ROB and drained in order to the D-cache. Each entry
// carries a branch mask so a mispredict can squash younger stores.
// Optional feature macro: SQ_FORWARD_EN (store-to-load forwarding).
module store_queue #(
   parameter int SQ_DEPTH = 8,
   parameter int B_MASK_W = 4,
   parameter int IDX_W    = $clog2(SQ_DEPTH)
) (
   input logic          clock,
   input logic          reset_n,
   store_queue_if.slave sq
);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_ALLOC  = 2'd1,
      ST_READY  = 2'd2,
      ST_COMMIT = 2'd3
   } entry_state_t;

   // entry storage
   entry_state_t        state_reg [SQ_DEPTH];
   logic [B_MASK_W-1:0] bm_reg    [SQ_DEPTH];
   logic [31:0]         addr_reg  [SQ_DEPTH];
   logic [31:0]         data_reg  [SQ_DEPTH];
   logic [3:0]          mask_reg  [SQ_DEPTH];

   // pointers carry a wrap bit above the index
   logic [PTR_W-1:0] head_reg, commit_reg, tail_reg, count_reg;
   logic [PTR_W-1:0] head_next, commit_next, tail_next;
   logic [IDX_W-1:0] head_idx, commit_idx, tail_idx;

   logic                full;
   logic                mispred_any;
   logic                alloc_fire;
   logic                dc_fire;
   logic [B_MASK_W-1:0] bm_clear;
   logic [B_MASK_W-1:0] alloc_bm_eff;
   logic [PTR_W-1:0]    live_cnt;

   // per-entry decode
   logic [IDX_W-1:0]    off_w [SQ_DEPTH];
   logic [SQ_DEPTH-1:0] live_w, pend_w, match_w, squash_w;
   logic [SQ_DEPTH-1:0] alloc_hit, in_hit, retire_hit, drain_hit;

   // squash search result: offset from commit of the oldest matching store
   logic             sq_found;
   logic [IDX_W-1:0] sq_off;

   assign head_idx   = head_reg[IDX_W-1:0];
   assign commit_idx = commit_reg[IDX_W-1:0];
   assign tail_idx   = tail_reg[IDX_W-1:0];

   assign full        = (head_idx == tail_idx) && (head_reg[IDX_W] != tail_reg[IDX_W]);
   assign mispred_any = sq.b_mm_mispred && (|sq.b_mm_resolve);

   // Full status uses the registered pointers, so a same-cycle drain does
   // not reopen allocation until the following cycle.
   assign sq.alloc_ready = !full && !mispred_any;
   assign sq.alloc_idx   = tail_idx;
   assign alloc_fire     = sq.alloc_valid && sq.alloc_ready;

   // A correctly resolved branch bit is removed everywhere, including the
   // mask of a store allocating in the same cycle.
   assign bm_clear     = (!sq.b_mm_mispred) ? sq.b_mm_resolve : '0;
   assign alloc_bm_eff = sq.alloc_bm & ~bm_clear;

   // Drain request is a pure decode of the head entry's registered fields.
   assign sq.dc_req_valid     = (state_reg[head_idx] == ST_COMMIT);
   assign sq.dc_req_addr      = addr_reg[head_idx] & WORD_MASK;
   assign sq.dc_req_data      = data_reg[head_idx];
   assign sq.dc_req_byte_mask = mask_reg[head_idx];
   assign dc_fire             = sq.dc_req_valid && sq.dc_req_ready;

   assign sq.sq_count = count_reg;

   // entries in [commit, tail) are the uncommitted, speculative ones
   assign live_cnt = tail_reg - commit_reg;

   for (genvar gi = 0; gi < SQ_DEPTH; gi++) begin : g_entry
      assign off_w[gi]      = IDX_W'(gi) - commit_idx;
      assign live_w[gi]     = ({1'b0, off_w[gi]} < live_cnt);
      assign pend_w[gi]     = (state_reg[gi] == ST_ALLOC) || (state_reg[gi] == ST_READY);
      assign match_w[gi]    = mispred_any && live_w[gi] && pend_w[gi] &&
                              (|(bm_reg[gi] & sq.b_mm_resolve));
      // everything from the oldest squashed store up to the tail goes away
      assign squash_w[gi]   = sq_found && live_w[gi] && pend_w[gi] && (off_w[gi] >= sq_off);
      assign alloc_hit[gi]  = alloc_fire && (tail_idx == IDX_W'(gi));
      // captures into a FREE, COMMITTED or just-squashed entry are dropped
      assign in_hit[gi]     = sq.sq_in_valid && (sq.sq_in_idx == IDX_W'(gi)) &&
                              pend_w[gi] && !squash_w[gi];
      assign retire_hit[gi] = sq.retire_valid && (commit_idx == IDX_W'(gi));
      assign drain_hit[gi]  = dc_fire && (head_idx == IDX_W'(gi));
   end

   // Find the oldest mispredict-matching entry, walking from commit to tail.
   always_comb begin
      sq_found = 1'b0;
      sq_off   = '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
         if (!sq_found && match_w[commit_idx + IDX_W'(i)]) begin
            sq_found = 1'b1;
            sq_off   = IDX_W'(i);
         end
      end
   end

   // Next-state pointers; a squash pulls the tail back to the oldest victim.
   always_comb begin
      head_next   = dc_fire ? head_reg + PTR_W'(1) : head_reg;
      commit_next = sq.retire_valid ? commit_reg + PTR_W'(1) : commit_reg;
      tail_next   = tail_reg;
      if (sq_found) begin
         tail_next = commit_reg + PTR_W'(sq_off);
      end else if (alloc_fire) begin
         tail_next = tail_reg + PTR_W'(1);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_reg   <= '0;
         commit_reg <= '0;
         tail_reg   <= '0;
         count_reg  <= '0;
      end else begin
         head_reg   <= head_next;
         commit_reg <= commit_next;
         tail_reg   <= tail_next;
         count_reg  <= tail_next - head_next;
      end
   end

   // Per-entry lifecycle, branch mask and payload capture.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SQ_DEPTH; i++) begin
            state_reg[i] <= ST_FREE;
            bm_reg[i]    <= '0;
            addr_reg[i]  <= '0;
            data_reg[i]  <= '0;
            mask_reg[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < SQ_DEPTH; i++) begin
            if (squash_w[i] || drain_hit[i]) begin
               state_reg[i] <= ST_FREE;
            end else if (retire_hit[i]) begin
               state_reg[i] <= ST_COMMIT;
            end else if (in_hit[i]) begin
               state_reg[i] <= ST_READY;
            end else if (alloc_hit[i]) begin
               state_reg[i] <= ST_ALLOC;
            end

            if (alloc_hit[i]) begin
               bm_reg[i] <= alloc_bm_eff;
            end else if (retire_hit[i]) begin
               bm_reg[i] <= '0;
            end else if (state_reg[i] != ST_FREE) begin
               bm_reg[i] <= bm_reg[i] & ~bm_clear;
            end

            if (in_hit[i]) begin
               addr_reg[i] <= sq.sq_in_addr;
               data_reg[i] <= sq.sq_in_data;
               mask_reg[i] <= sq.sq_in_byte_mask;
            end
         end
      end
   end

   // The ROB may only retire a store whose address and data are present.
   a_retire_ready : assert property (@(posedge clock) disable iff (!reset_n)
      sq.retire_valid |-> (state_reg[commit_idx] == ST_READY));

`ifdef SQ_FORWARD_EN
   logic             fwd_found;
   logic [IDX_W-1:0] fwd_sel;
   logic [IDX_W-1:0] fwd_probe;
   logic [PTR_W-1:0] fwd_span;

   // Youngest filled store older than the load's tail snapshot, same word.
   always_comb begin
      fwd_found = 1'b0;
      fwd_sel   = '0;
      fwd_probe = '0;
      fwd_span  = sq.ld_tail - head_reg;
      for (int i = 0; i < SQ_DEPTH; i++) begin
         fwd_probe = sq.ld_tail[IDX_W-1:0] - IDX_W'(i) - IDX_W'(1);
         if (!fwd_found && (PTR_W'(i) < fwd_span) &&
             ((state_reg[fwd_probe] == ST_READY) || (state_reg[fwd_probe] == ST_COMMIT)) &&
             (((addr_reg[fwd_probe] ^ sq.ld_addr) & WORD_MASK) == 32'd0)) begin
            fwd_found = 1'b1;
            fwd_sel   = fwd_probe;
         end
      end
   end

   // Forward only when that store supplies every byte the load needs.
   always_comb begin
      sq.fwd_hit  = sq.ld_valid && fwd_found &&
                    ((mask_reg[fwd_sel] & sq.ld_byte_mask) == sq.ld_byte_mask);
      sq.fwd_data = sq.fwd_hit ? data_reg[fwd_sel] : 32'd0;
   end
`endif

endmodule
